// File: rtl/adc_spi_reader_if.sv
// Bundles the ADC pins, the downstream sample strobe and the run control of adc_spi_reader.
// Ports: enable/adc_sdo into the reader; adc_cnv/adc_cs_n/adc_sclk to the ADC; adc_data/adc_ready/busy downstream.
// Latency: n/a (wiring only). Backpressure: none; adc_ready is a one-cycle strobe with no ready return.
interface adc_spi_reader_if;
  logic        enable;
  logic        adc_sdo;
  logic        adc_cnv;
  logic        adc_cs_n;
  logic        adc_sclk;
  logic [15:0] adc_data;
  logic        adc_ready;
  logic        busy;

  // master: the reader itself
  modport master (
    input  enable, adc_sdo,
    output adc_cnv, adc_cs_n, adc_sclk, adc_data, adc_ready, busy
  );

  // slave: the ADC plus the downstream consumer / controller
  modport slave (
    output enable, adc_sdo,
    input  adc_cnv, adc_cs_n, adc_sclk, adc_data, adc_ready, busy
  );
endinterface

// File: rtl/adc_spi_reader.sv
// Drives a conversion-start / SPI-read cycle on a 16-bit ADC and strobes each raw sample downstream.
// Ports: clk, rst (async active-high), bus (adc_spi_reader_if.master). Latency: CONV_CYCLES + 32*CLK_DIV + 1 from start.
// Backpressure: none; adc_ready is a one-cycle strobe and adc_data holds until the next strobe.
module adc_spi_reader #(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned CONV_CYCLES = 40
) (
  input  logic                    clk,
  input  logic                    rst,
  adc_spi_reader_if.master        bus
);

  typedef enum logic [1:0] {IDLE, CONVERT, SHIFT, DONE} state_t;

  // Counters sized for the parameter maxima (1023 / 255 / 32 half periods).
  localparam logic [9:0] CONV_LAST = 10'(CONV_CYCLES - 1);
  localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);

  state_t      state_q, state_d;
  logic [9:0]  conv_cnt_q, conv_cnt_d;
  logic [7:0]  div_cnt_q, div_cnt_d;
  logic [4:0]  half_cnt_q, half_cnt_d;
  logic [15:0] shift_q, shift_d;
  logic [15:0] data_q, data_d;
  logic        cnv_q, cnv_d;
  logic        cs_n_q, cs_n_d;
  logic        sclk_q, sclk_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;

  always_comb begin
    state_d    = state_q;
    conv_cnt_d = conv_cnt_q;
    div_cnt_d  = div_cnt_q;
    half_cnt_d = half_cnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    sclk_d     = sclk_q;

    case (state_q)
      IDLE: begin
        conv_cnt_d = '0;
        div_cnt_d  = '0;
        half_cnt_d = '0;
        sclk_d     = 1'b0;
        if (bus.enable) state_d = CONVERT;
      end
      CONVERT: begin
        if (conv_cnt_q == CONV_LAST) begin
          conv_cnt_d = '0;
          state_d    = SHIFT;
        end else begin
          conv_cnt_d = conv_cnt_q + 10'd1;
        end
      end
      SHIFT: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          sclk_d    = ~sclk_q;
          if (!sclk_q) begin
            // The edge that raises SCLK also captures SDO; the ADC updates SDO on SCLK falling.
            shift_d    = {shift_q[14:0], bus.adc_sdo};
            half_cnt_d = half_cnt_q + 5'd1;
          end else if (half_cnt_q == 5'd31) begin
            // 16th falling edge: SCLK is left low on exit.
            half_cnt_d = '0;
            state_d    = DONE;
          end else begin
            half_cnt_d = half_cnt_q + 5'd1;
          end
        end else begin
          div_cnt_d = div_cnt_q + 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so each pin is valid in the state it belongs to.
    cnv_d   = (state_d == CONVERT);
    cs_n_d  = (state_d != SHIFT);
    ready_d = (state_d == DONE);
    busy_d  = (state_d != IDLE);
    if (state_d == DONE && state_q != DONE) data_d = shift_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      conv_cnt_q <= '0;
      div_cnt_q  <= '0;
      half_cnt_q <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      cnv_q      <= 1'b0;
      cs_n_q     <= 1'b1;
      sclk_q     <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      conv_cnt_q <= conv_cnt_d;
      div_cnt_q  <= div_cnt_d;
      half_cnt_q <= half_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      cnv_q      <= cnv_d;
      cs_n_q     <= cs_n_d;
      sclk_q     <= sclk_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.adc_cnv   = cnv_q;
  assign bus.adc_cs_n  = cs_n_q;
  assign bus.adc_sclk  = sclk_q;
  assign bus.adc_data  = data_q;
  assign bus.adc_ready = ready_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_adc_spi_reader.sv
// Bench for adc_spi_reader: default instance (DIV 4, CONV 40) and a fast instance (DIV 1, CONV 1).
// Ports: none. An SPI ADC model serves words from a queue; a monitor scores each adc_ready strobe.
// Backpressure: n/a; strobes are consumed unconditionally.
module tb_adc_spi_reader;

  logic clk;
  logic rst;

  adc_spi_reader_if if0();
  adc_spi_reader_if if1();

  adc_spi_reader #(.CLK_DIV(4), .CONV_CYCLES(40)) dut0 (.clk(clk), .rst(rst), .bus(if0.master));
  adc_spi_reader #(.CLK_DIV(1), .CONV_CYCLES(1))  dut1 (.clk(clk), .rst(rst), .bus(if1.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    int          gap;   // expected cycles since previous strobe, 0 = do not check
    int          inst;
  } exp_t;

  exp_t        eq[$];
  logic [15:0] mq[$];
  int          checks = 0;
  int          errors = 0;
  int          strobes = 0;
  int          cdiv[2] = '{4, 1};
  int          cconv[2] = '{40, 1};

  logic [1:0]  rdy, csn, sclk, cnv, bsy;
  logic [15:0] dat[2];
  assign rdy  = {if1.adc_ready, if0.adc_ready};
  assign csn  = {if1.adc_cs_n, if0.adc_cs_n};
  assign sclk = {if1.adc_sclk, if0.adc_sclk};
  assign cnv  = {if1.adc_cnv, if0.adc_cnv};
  assign bsy  = {if1.busy, if0.busy};
  assign dat[0] = if0.adc_data;
  assign dat[1] = if1.adc_data;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic exp_push(input logic [15:0] d, input int g, input int i);
    exp_t e;
    e.data = d; e.gap = g; e.inst = i;
    eq.push_back(e);
  endtask

  // ADC model: MSB presented after CS falls, next bit after each SCLK fall.
  logic [15:0] mword[2];
  int          midx[2];
  logic        m_csn[2] = '{1'b1, 1'b1};
  logic        m_sclk[2] = '{1'b0, 1'b0};
  logic        sdo_v[2] = '{1'b0, 1'b0};

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (m_csn[k] && !csn[k]) begin
        mword[k] = (mq.size() > 0) ? mq.pop_front() : 16'h0000;
        midx[k]  = 15;
        sdo_v[k] = mword[k][15];
      end else if (!csn[k] && m_sclk[k] && !sclk[k] && midx[k] > 0) begin
        midx[k]  = midx[k] - 1;
        sdo_v[k] = mword[k][midx[k]];
      end
      m_csn[k]  = csn[k];
      m_sclk[k] = sclk[k];
    end
    if0.adc_sdo = sdo_v[0];
    if1.adc_sdo = sdo_v[1];
  end

  // Monitor / scoreboard
  int   cyc = 0;
  int   last_strobe[2] = '{0, 0};
  int   cnv_len[2] = '{0, 0};
  int   rises[2] = '{0, 0};
  int   hi_len[2] = '{0, 0};
  logic p_cnv[2] = '{1'b0, 1'b0};
  logic p_sclk[2] = '{1'b0, 1'b0};
  logic p_rdy[2] = '{1'b0, 1'b0};
  logic gate = 1'b0;
  int   acc = 0;
  int   acc_n = 0;
  exp_t e_m;

  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        cnv_len[k] = 0; rises[k] = 0; hi_len[k] = 0;
        p_cnv[k] = 1'b0; p_sclk[k] = 1'b0; p_rdy[k] = 1'b0;
      end else begin
        if (cnv[k]) begin
          if (!p_cnv[k]) begin cnv_len[k] = 1; rises[k] = 0; end
          else cnv_len[k]++;
        end
        if (sclk[k]) begin
          if (!p_sclk[k]) begin rises[k]++; hi_len[k] = 1; end
          else hi_len[k]++;
        end else if (p_sclk[k]) begin
          chk($sformatf("sclk_high_len%0d", k), hi_len[k], cdiv[k]);
        end
        if (rdy[k]) begin
          chk($sformatf("ready_one_cycle%0d", k), int'(p_rdy[k]), 0);
          strobes++;
          if (eq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_strobe%0d: got data 0x%0h, expected no strobe", k, dat[k]);
          end else begin
            e_m = eq.pop_front();
            chk("strobe_instance", k, e_m.inst);
            chk($sformatf("adc_data%0d", k), int'(dat[k]), int'(e_m.data));
            if (e_m.gap > 0) chk($sformatf("strobe_gap%0d", k), cyc - last_strobe[k], e_m.gap);
            chk($sformatf("cnv_cycles%0d", k), cnv_len[k], cconv[k]);
            chk($sformatf("sclk_rises%0d", k), rises[k], 16);
          end
          last_strobe[k] = cyc;
          if (gate) begin acc += int'(dat[k]); acc_n++; end
        end
        p_cnv[k] = cnv[k]; p_sclk[k] = sclk[k]; p_rdy[k] = rdy[k];
      end
    end
  end

  task automatic wait_strobes(input int target, input int budget);
    int n = 0;
    while (strobes < target && n < budget) begin @(negedge clk); n++; end
    chk("strobe_wait", int'(strobes >= target), 1);
  endtask

  task automatic wait_idle(input int k, input int budget);
    int n = 0;
    while (bsy[k] && n < budget) begin @(negedge clk); n++; end
    chk("idle_wait", int'(bsy[k]), 0);
  endtask

  task automatic wait_csn_low(input int k, input int budget);
    int n = 0;
    while (csn[k] && n < budget) begin @(negedge clk); n++; end
    chk("cs_low_wait", int'(csn[k]), 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cnv"},   int'(if0.adc_cnv), 0);
    chk({tag, "_cs_n"},  int'(if0.adc_cs_n), 1);
    chk({tag, "_sclk"},  int'(if0.adc_sclk), 0);
    chk({tag, "_data"},  int'(if0.adc_data), 0);
    chk({tag, "_ready"}, int'(if0.adc_ready), 0);
    chk({tag, "_busy"},  int'(if0.busy), 0);
  endtask

  initial begin
    int base;
    int hits;
    rst = 1'b1;
    if0.enable = 1'b0;
    if1.enable = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single sample 0xA5C3 at defaults
    mq.push_back(16'hA5C3); exp_push(16'hA5C3, 0, 0);
    if0.enable = 1'b1; @(negedge clk); if0.enable = 1'b0;
    wait_strobes(1, 400); wait_idle(0, 50);

    // Continuous sampling, strobes 170 cycles apart
    base = strobes;
    mq.push_back(16'h0000); mq.push_back(16'hFFFF); mq.push_back(16'h8001);
    exp_push(16'h0000, 0, 0); exp_push(16'hFFFF, 170, 0); exp_push(16'h8001, 170, 0);
    if0.enable = 1'b1;
    wait_strobes(base + 2, 600);
    repeat (3) @(negedge clk);
    if0.enable = 1'b0;
    wait_strobes(base + 3, 400); wait_idle(0, 50);
    repeat (200) @(negedge clk);
    chk("continuous_strobe_count", strobes - base, 3);

    // enable dropped mid-SHIFT: one strobe, then stay idle
    base = strobes;
    mq.push_back(16'h1234); exp_push(16'h1234, 0, 0);
    if0.enable = 1'b1;
    wait_csn_low(0, 100);
    repeat (42) @(negedge clk);
    if0.enable = 1'b0;
    wait_strobes(base + 1, 400); wait_idle(0, 50);
    hits = 0;
    repeat (200) begin @(negedge clk); if (if0.adc_cnv || if0.busy) hits++; end
    chk("stopped_cnv_busy", hits, 0);
    chk("stopped_strobe_count", strobes - base, 1);

    // Reset mid-SHIFT: immediate reset values, aborted sample never strobes
    base = strobes;
    mq.push_back(16'hDEAD);
    if0.enable = 1'b1;
    wait_csn_low(0, 100);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1;
    chk_reset_vals("async_reset");
    if0.enable = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    chk("aborted_no_strobe", strobes - base, 0);
    mq.push_back(16'h3C3C); exp_push(16'h3C3C, 0, 0);
    if0.enable = 1'b1; @(negedge clk); if0.enable = 1'b0;
    wait_strobes(base + 1, 400); wait_idle(0, 50);

    // Downstream accumulation: 5 samples of 12 inside the gate window
    base = strobes;
    acc = 0; acc_n = 0; gate = 1'b1;
    for (int i = 0; i < 5; i++) begin
      mq.push_back(16'h000C);
      exp_push(16'h000C, (i == 0) ? 0 : 170, 0);
    end
    if0.enable = 1'b1;
    wait_strobes(base + 4, 900);
    repeat (3) @(negedge clk);
    if0.enable = 1'b0;
    wait_strobes(base + 5, 400); wait_idle(0, 50);
    gate = 1'b0;
    chk("accum_sum", acc, 60);
    chk("accum_count", acc_n, 5);

    // Fast instance: SCLK toggles every clk, period 35
    base = strobes;
    mq.push_back(16'h5A5A); exp_push(16'h5A5A, 0, 1);
    if1.enable = 1'b1; @(negedge clk); if1.enable = 1'b0;
    wait_strobes(base + 1, 100); wait_idle(1, 20);
    mq.push_back(16'h5A5A); mq.push_back(16'h0001);
    exp_push(16'h5A5A, 0, 1); exp_push(16'h0001, 35, 1);
    if1.enable = 1'b1;
    wait_strobes(base + 2, 100);
    repeat (3) @(negedge clk);
    if1.enable = 1'b0;
    wait_strobes(base + 3, 100); wait_idle(1, 20);

    repeat (20) @(negedge clk);
    chk("scoreboard_drained", eq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_spi_reader.md
ADC_SPI_READER -- requirements
Module: adc_spi_reader

Interface
REQ-001 Parameter CLK_DIV, default 4, clk cycles per SCLK half-period, legal range 1..255.
REQ-002 Parameter CONV_CYCLES, default 40, clk cycles adc_cnv is held high per conversion, legal range 1..1023.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  high = continuous sampling; low = stop after current sample.
REQ-006 adc_sdo  input  1  serial data from ADC, MSB first.
REQ-007 adc_cnv  output  1  conversion start to ADC.
REQ-008 adc_cs_n  output  1  ADC chip select, active low.
REQ-009 adc_sclk  output  1  serial clock to ADC.
REQ-010 adc_data  output  16  last completed sample; feeds downstream adc_data.
REQ-011 adc_ready  output  1  one-cycle strobe, adc_data valid; feeds downstream adc_ready.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 FSM states SHALL be IDLE, CONVERT, SHIFT and DONE; all outputs SHALL be registered.
REQ-014 IDLE: enable=1 at a clk edge -> CONVERT next cycle; enable=0 -> remain in IDLE.
REQ-015 CONVERT: adc_cnv=1 for exactly CONV_CYCLES cycles, adc_cs_n=1, adc_sclk=0; then -> SHIFT.
REQ-016 SHIFT: adc_cs_n=0 and adc_cnv=0; adc_sclk starts low and toggles every CLK_DIV cycles, 16 full periods, 32*CLK_DIV cycles total.
REQ-017 adc_sdo SHALL be sampled into the shift register on the same clk edge that drives adc_sclk 0->1, MSB first, 16 samples.
REQ-018 After the 16th falling adc_sclk -> DONE; adc_sclk SHALL end low.
REQ-019 DONE, one cycle: adc_data=shift register, adc_ready=1, adc_cs_n=1; next state IDLE.
REQ-020 adc_ready SHALL be high for exactly one cycle per sample and never otherwise.
REQ-021 adc_data SHALL hold its value between strobes and change only on the DONE cycle.
REQ-022 Sample period with enable held high = CONV_CYCLES + 32*CLK_DIV + 2 cycles; 170 at defaults.
REQ-023 enable deasserted in CONVERT or SHIFT: sample SHALL complete, strobe once, then remain in IDLE.
REQ-024 enable pulses while busy=1 SHALL be ignored; no request is queued.
REQ-025 Internal counters SHALL be wide enough for parameter maxima, with no wrap within a state.
REQ-026 No sign extension or arithmetic on data; the 16-bit raw code is passed through unchanged.

Reset
REQ-027 rst=1 SHALL force, asynchronously: state=IDLE, adc_cnv=0, adc_cs_n=1, adc_sclk=0, adc_data=0x0000, adc_ready=0, busy=0, all counters and the shift register cleared.
REQ-028 Reset during SHIFT or CONVERT SHALL discard the partial sample; no adc_ready after release.
REQ-029 After rst falls, the first conversion SHALL start on the first clk edge with enable=1.

Verification
REQ-030 Defaults; SDO model returns 0xA5C3; enable=1 for one sample -> adc_cnv high 40 cycles, 16 SCLK periods of 8 cycles, adc_data=0xA5C3 with adc_ready high 1 cycle.
REQ-031 enable held high, model returns 0x0000 then 0xFFFF then 0x8001 -> strobes exactly 170 cycles apart carrying those values in order.
REQ-032 enable dropped at SHIFT bit 5 -> sample completes, exactly one strobe, busy=0 afterward, adc_cnv stays 0.
REQ-033 rst pulsed mid-SHIFT -> immediate reset values per REQ-027, no strobe for the aborted sample, next sample correct.
REQ-034 CLK_DIV=1, CONV_CYCLES=1 -> SCLK toggles every cycle, period 35 cycles, data correct for 0x5A5A.
REQ-035 Chain to downstream accumulator, 5 samples of 12 inside a gate window -> downstream result sum 60, counter id propagated.
